// File: rtl/hdmi_pkg.sv
// Shared HDMI definitions: period encodings, preamble control words, guard-band codes and
// pipeline constants.
package hdmi_pkg;

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_PRE   = 2'd1,
    MODE_GUARD = 2'd2,
    MODE_VIDEO = 2'd3
  } mode_e;

  localparam int LAT       = 10;
  localparam int PRE_LEN   = 8;
  localparam int GUARD_LEN = 2;

  // Video-preamble CTL3..CTL0 = 4'b0001, carried on cd2:cd1.
  localparam logic [1:0] PRE_CD1 = 2'b01;
  localparam logic [1:0] PRE_CD2 = 2'b00;

  localparam logic [9:0] GUARD_CH0 = 10'b1011001100;
  localparam logic [9:0] GUARD_CH1 = 10'b0100110011;
  localparam logic [9:0] GUARD_CH2 = 10'b1011001100;

  function automatic logic [9:0] guard_code(input logic [1:0] ch);
    case (ch)
      2'd1:    return GUARD_CH1;
      2'd2:    return GUARD_CH2;
      default: return GUARD_CH0;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_period_ctrl_if.sv
// Timing/colour inputs and encoder-side outputs of the HDMI period controller.
interface hdmi_period_ctrl_if;
  logic       de, hsync, vsync;
  logic [7:0] r, g, b;
  logic [7:0] vd_r, vd_g, vd_b;
  logic [1:0] cd0, cd1, cd2;
  logic [1:0] mode;
  logic       vde, guard, timing_err;

  modport master (
    output de, hsync, vsync, r, g, b,
    input  vd_r, vd_g, vd_b, cd0, cd1, cd2, mode, vde, guard, timing_err
  );

  modport slave (
    input  de, hsync, vsync, r, g, b,
    output vd_r, vd_g, vd_b, cd0, cd1, cd2, mode, vde, guard, timing_err
  );
endinterface

// File: rtl/hdmi_period_ctrl_delay_line.sv
// Fixed-depth register delay line with synchronous clear.
module delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/hdmi_period_ctrl.sv
// HDMI period sequencer: delays timing and colour by LAT cycles and inserts a preamble
// and guard band ahead of every video line, with all outputs aligned to the delayed pixels.
module hdmi_period_ctrl
  import hdmi_pkg::*;
#(
  parameter bit DVI_MODE = 1'b0
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  hdmi_period_ctrl_if.slave  bus
);

  localparam int DW = 27;

  logic [DW-1:0] dl_in, dl_out;
  logic          de_d, hs_d, vs_d;
  logic [23:0]   rgb_d;

  assign dl_in = {bus.de, bus.hsync, bus.vsync, bus.r, bus.g, bus.b};

  delay_line #(.W(DW), .DEPTH(LAT)) u_delay (
    .clk  (clk_pix),
    .rst  (rst_pix),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign {de_d, hs_d, vs_d, rgb_d} = dl_out;

  mode_e       state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        de_prev_q, de_prev_d;
  logic        err_q, err_d;
  logic        vde_q, vde_d;
  logic        guard_q, guard_d;
  logic [1:0]  cd0_q, cd0_d, cd1_q, cd1_d, cd2_q, cd2_d;
  logic [23:0] vd_q, vd_d;
  logic        de_rise;

  always_comb begin
    de_rise   = bus.de & ~de_prev_q;
    de_prev_d = bus.de;
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    if (de_d) begin
      state_d = MODE_VIDEO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        MODE_PRE: begin
          if (cnt_q == '0) begin
            state_d = MODE_GUARD;
            cnt_d   = 3'(GUARD_LEN - 1);
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        MODE_GUARD: begin
          if (cnt_q == '0) state_d = MODE_CTRL;
          else             cnt_d   = cnt_q - 3'd1;
        end
        default: begin
          // Idle, or the last video cycle: a new line with a gap of exactly LAT may start here.
          state_d = MODE_CTRL;
          cnt_d   = '0;
          if (de_rise && !DVI_MODE) begin
            state_d = MODE_PRE;
            cnt_d   = 3'(PRE_LEN - 1);
          end
        end
      endcase
    end

    // An edge that cannot get a full preamble + guard ahead of its delayed data is dropped.
    if (!DVI_MODE && de_rise &&
        (de_d || state_q == MODE_PRE || state_q == MODE_GUARD))
      err_d = 1'b1;

    vde_d   = (state_d == MODE_VIDEO);
    guard_d = (state_d == MODE_GUARD);
    cd0_d   = vde_d ? 2'b00 : {vs_d, hs_d};
    cd1_d   = (state_d == MODE_PRE) ? PRE_CD1 : 2'b00;
    cd2_d   = (state_d == MODE_PRE) ? PRE_CD2 : 2'b00;
    vd_d    = rgb_d;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q   <= MODE_CTRL;
      cnt_q     <= '0;
      de_prev_q <= 1'b0;
      err_q     <= 1'b0;
      vde_q     <= 1'b0;
      guard_q   <= 1'b0;
      cd0_q     <= '0;
      cd1_q     <= '0;
      cd2_q     <= '0;
      vd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      de_prev_q <= de_prev_d;
      err_q     <= err_d;
      vde_q     <= vde_d;
      guard_q   <= guard_d;
      cd0_q     <= cd0_d;
      cd1_q     <= cd1_d;
      cd2_q     <= cd2_d;
      vd_q      <= vd_d;
    end
  end

  assign bus.mode       = state_q;
  assign bus.vde        = vde_q;
  assign bus.guard      = guard_q;
  assign bus.timing_err = err_q;
  assign bus.cd0        = cd0_q;
  assign bus.cd1        = cd1_q;
  assign bus.cd2        = cd2_q;
  assign bus.vd_r       = vd_q[23:16];
  assign bus.vd_g       = vd_q[15:8];
  assign bus.vd_b       = vd_q[7:0];

endmodule

// File: tb/tb_hdmi_period_ctrl.sv
// Scoreboard bench: HDMI and DVI instances share stimulus; expected outputs come from a
// line/gap model of the input history and are checked every cycle by a separate monitor.
module tb_hdmi_period_ctrl;
  import hdmi_pkg::*;

  logic clk_pix = 1'b0;
  logic rst_pix;
  always #5 clk_pix = ~clk_pix;

  hdmi_period_ctrl_if ifh ();
  hdmi_period_ctrl_if ifd ();

  assign ifd.de    = ifh.de;
  assign ifd.hsync = ifh.hsync;
  assign ifd.vsync = ifh.vsync;
  assign ifd.r     = ifh.r;
  assign ifd.g     = ifh.g;
  assign ifd.b     = ifh.b;

  hdmi_period_ctrl #(.DVI_MODE(1'b0)) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .bus     (ifh)
  );

  hdmi_period_ctrl #(.DVI_MODE(1'b1)) dut_dvi (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .bus     (ifd)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic        vde, guard, err;
    logic [1:0]  cd0, cd1, cd2;
    logic [23:0] rgb;
  } out_t;

  out_t qh[$], qd[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam int MAXC = 32768;
  logic        de_h [MAXC];
  logic        hs_h [MAXC];
  logic        vs_h [MAXC];
  logic [23:0] rgb_h[MAXC];
  int          cyc  = 0;
  int          base = 0;
  int          lh   = -1000;  // last sample with de high
  int          acc  = -1000;  // last de edge that earned a preamble
  bit          err  = 1'b0;

  // One input sample; the expectation for the clock edge that samples it is queued here.
  task automatic step(input bit rst, input bit de, input bit hs, input bit vs, input logic [23:0] rgb);
    out_t eh, ed;
    int   j, dm;
    bit   dj, hj, vj, prev;
    logic [23:0] cj;
    @(negedge clk_pix);
    rst_pix   = rst;
    ifh.de    = de;
    ifh.hsync = hs;
    ifh.vsync = vs;
    {ifh.r, ifh.g, ifh.b} = rgb;
    eh = '0;
    ed = '0;
    if (rst) begin
      base = cyc + 1;
      lh   = -1000;
      acc  = -1000;
      err  = 1'b0;
    end else begin
      de_h[cyc] = de; hs_h[cyc] = hs; vs_h[cyc] = vs; rgb_h[cyc] = rgb;
      prev = (cyc - 1 >= base) ? de_h[cyc-1] : 1'b0;
      if (de && !prev) begin
        if (lh >= base && (cyc - 1 - lh) < LAT) err = 1'b1;
        else                                    acc = cyc;
      end
      if (de) lh = cyc;
      j = cyc - LAT;
      dj = 1'b0; hj = 1'b0; vj = 1'b0; cj = '0;
      if (j >= base) begin
        dj = de_h[j]; hj = hs_h[j]; vj = vs_h[j]; cj = rgb_h[j];
      end
      dm = cyc - acc;
      eh.rgb = cj;
      if (dj)                           eh.mode = 2'd3;
      else if (dm < PRE_LEN)            eh.mode = 2'd1;
      else if (dm < PRE_LEN + GUARD_LEN) eh.mode = 2'd2;
      else                              eh.mode = 2'd0;
      eh.vde   = (eh.mode == 2'd3);
      eh.guard = (eh.mode == 2'd2);
      eh.err   = err;
      eh.cd0   = (eh.mode == 2'd3) ? 2'b00 : {vj, hj};
      eh.cd1   = (eh.mode == 2'd1) ? 2'b01 : 2'b00;
      ed.rgb   = cj;
      ed.mode  = dj ? 2'd3 : 2'd0;
      ed.vde   = dj;
      ed.cd0   = dj ? 2'b00 : {vj, hj};
    end
    qh.push_back(eh);
    qd.push_back(ed);
    cyc++;
  endtask

  task automatic idle(input int n, input bit hs = 1'b0, input bit vs = 1'b0);
    repeat (n) step(1'b0, 1'b0, hs, vs, 24'($urandom()));
  endtask

  task automatic line(input int n, input bit hs = 1'b0, input bit vs = 1'b0);
    repeat (n) step(1'b0, 1'b1, hs, vs, 24'($urandom()));
  endtask

  out_t eh_m, ed_m, ah_m, ad_m;

  initial begin
    forever begin
      @(posedge clk_pix);
      #1;
      if (qh.size() > 0 && qd.size() > 0) begin
        eh_m = qh.pop_front();
        ed_m = qd.pop_front();
        ah_m = {ifh.mode, ifh.vde, ifh.guard, ifh.timing_err, ifh.cd0, ifh.cd1, ifh.cd2,
                ifh.vd_r, ifh.vd_g, ifh.vd_b};
        ad_m = {ifd.mode, ifd.vde, ifd.guard, ifd.timing_err, ifd.cd0, ifd.cd1, ifd.cd2,
                ifd.vd_r, ifd.vd_g, ifd.vd_b};
        n_chk++;
        if (ah_m === eh_m) n_pass++;
        else $display("FAIL hdmi_out t=%0t got mode=%0d vde=%b grd=%b err=%b cd=%b/%b/%b rgb=%h exp mode=%0d vde=%b grd=%b err=%b cd=%b/%b/%b rgb=%h",
                      $time, ah_m.mode, ah_m.vde, ah_m.guard, ah_m.err, ah_m.cd0, ah_m.cd1, ah_m.cd2, ah_m.rgb,
                      eh_m.mode, eh_m.vde, eh_m.guard, eh_m.err, eh_m.cd0, eh_m.cd1, eh_m.cd2, eh_m.rgb);
        n_chk++;
        if (ad_m === ed_m) n_pass++;
        else $display("FAIL dvi_out t=%0t got mode=%0d vde=%b grd=%b err=%b cd=%b/%b/%b rgb=%h exp mode=%0d vde=%b grd=%b err=%b cd=%b/%b/%b rgb=%h",
                      $time, ad_m.mode, ad_m.vde, ad_m.guard, ad_m.err, ad_m.cd0, ad_m.cd1, ad_m.cd2, ad_m.rgb,
                      ed_m.mode, ed_m.vde, ed_m.guard, ed_m.err, ed_m.cd0, ed_m.cd1, ed_m.cd2, ed_m.rgb);
      end
    end
  end

  initial begin
    rst_pix   = 1'b1;
    ifh.de    = 1'b0;
    ifh.hsync = 1'b0;
    ifh.vsync = 1'b0;
    {ifh.r, ifh.g, ifh.b} = '0;

    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);

    // Single short line after a long idle gap.
    idle(20); line(4); idle(30);
    // Syncs visible on cd0 in control periods.
    idle(5, 1'b1, 1'b0); line(4, 1'b1, 1'b0); idle(30, 1'b1, 1'b0);
    // Gap of 5, then the boundary gaps 10 (legal) and 9 (too short).
    line(12); idle(5); line(12); idle(30);
    line(12); idle(10); line(12); idle(9); line(12); idle(30);

    for (int k = 0; k < 30; k++) begin
      int ln, gp;
      ln = $urandom_range(40, 10);
      gp = ($urandom_range(3) == 0) ? $urandom_range(9, 5) : $urandom_range(25, 10);
      for (int i = 0; i < ln; i++)
        step(1'b0, 1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 24'($urandom()));
      for (int i = 0; i < gp; i++)
        step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 24'($urandom()));
    end
    idle(20);

    // Reset lands on the third preamble cycle, then a fresh line.
    idle(5); line(2); idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    idle(20); line(5); idle(25);

    // Two frames of 640-pixel lines with realistic blanking.
    for (int f = 0; f < 2; f++)
      for (int ln = 0; ln < 9; ln++)
        for (int x = 0; x < 800; x++)
          step(1'b0, (ln < 6) && (x < 640), (x >= 656) && (x < 752), ln == 7, 24'($urandom()));
    idle(15);

    for (int k = 0; k < 5 && (qh.size() > 0 || qd.size() > 0); k++) @(posedge clk_pix);
    #2;
    n_chk++;
    if (qh.size() == 0 && qd.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d/%0d pending required=0", qh.size(), qd.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hdmi_period_ctrl.md
HDMI_PERIOD_CTRL -- requirements
Module: hdmi_period_ctrl

Interface
REQ-001 Parameter DVI_MODE, default 0, meaning 1 = DVI output (no preamble or guard band) and 0 = HDMI video period sequencing.
REQ-002 Port clk_pix  input  1  pixel clock; the block's only clock.
REQ-003 Port rst_pix  input  1  reset, synchronous, active-high.
REQ-004 Port de  input  1  display-timing data enable, undelayed.
REQ-005 Port hsync, vsync  input  1 each  display-timing syncs, undelayed.
REQ-006 Port r, g, b  input  8 each  pixel colour, aligned with de.
REQ-007 Port vd_r, vd_g, vd_b  output  8 each  delayed colour to the channel 2/1/0 encoders.
REQ-008 Port cd0, cd1, cd2  output  2 each  control data to the channel 0/1/2 encoders.
REQ-009 Port mode  output  2  period of the current cycle: 0 CTRL, 1 PREAMBLE, 2 GUARD, 3 VIDEO.
REQ-010 Port vde  output  1  encoder video enable; 1 only when mode = VIDEO.
REQ-011 Port guard  output  1  1 when downstream must substitute the guard-band codes for the encoder output.
REQ-012 Port timing_err  output  1  sticky flag: the DE gap was too short for preamble plus guard.

Function
REQ-013 de, hsync, vsync, r, g and b shall pass through a 10-stage register delay line, giving de_d, hs_d, vs_d and rgb_d.
REQ-014 vd_r, vd_g and vd_b shall equal rgb_d, so input-to-output latency is exactly 10 clk_pix cycles.
REQ-015 The FSM shall have states CTRL, PREAMBLE, GUARD and VIDEO, with an internal 3-bit down-counter cnt.
REQ-016 A rising edge of de is de = 1 with the previous-cycle de = 0, using a dedicated edge register.
REQ-017 Transition CTRL -> PREAMBLE shall occur on a de rising edge when DVI_MODE = 0; cnt loads 7.
REQ-018 PREAMBLE shall last exactly 8 cycles (cnt 7..0), then move to GUARD with cnt loaded 1.
REQ-019 GUARD shall last exactly 2 cycles, then move to VIDEO, coinciding with the first de_d = 1 cycle.
REQ-020 In any state, de_d = 1 shall force the next state to VIDEO; this rule has priority over REQ-017..REQ-019.
REQ-021 VIDEO -> CTRL shall occur on the first cycle with de_d = 0.
REQ-022 A de rising edge in VIDEO (gap below 10 cycles) shall set timing_err and be ignored; video is then output with no preamble or guard.
REQ-023 A de rising edge in PREAMBLE or GUARD shall set timing_err and be ignored.
REQ-024 When DVI_MODE = 1, only CTRL and VIDEO shall be used, and timing_err shall stay 0.
REQ-025 cd0 shall equal {vs_d, hs_d} in every non-VIDEO state.
REQ-026 cd1 and cd2 shall be 2'b01 and 2'b00 in PREAMBLE, and 2'b00 in CTRL and GUARD.
REQ-027 In VIDEO, cd0, cd1 and cd2 shall be don't-care and driven to 0.
REQ-028 guard shall be 1 exactly in GUARD state.
REQ-029 mode, vde, guard and cd* shall be registered outputs, aligned cycle-for-cycle with vd_*.
REQ-030 In every state, vd_* shall carry rgb_d unmodified.

Reset
REQ-031 rst_pix shall clear all delay-line stages, force the FSM to CTRL and set cnt = 0.
REQ-032 rst_pix shall clear timing_err and drive mode = 0, vde = 0, guard = 0, cd* = 0 and vd_* = 0 on the next edge.
REQ-033 A reset during PREAMBLE, GUARD or VIDEO shall abort immediately, with no trailing guard.
REQ-034 After reset, the first de rising edge shall sequence normally.

Structure
REQ-035 The shared package hdmi_pkg shall hold the mode encodings, the preamble CTL constants and the 10-bit guard codes: ch0 = ch2 = 1011001100, ch1 = 0100110011.
REQ-036 The package shall also hold the delay constant LAT = 10, with PRE_LEN = 8 and GUARD_LEN = 2.
REQ-037 One sub-module shall be used: delay_line, parameterised by width and depth, instantiated once for {de, hsync, vsync, rgb}.
REQ-038 The three encoder instances and the final guard-code mux are outside this block.

Verification
REQ-039 Reset, then a de pulse of 4 cycles after 20 idle cycles: mode = 1 for 8 cycles, then 2 for 2 cycles, then 3 for 4 cycles, then 0; vd_* first valid at 10 cycles after the de edge.
REQ-040 hsync = 1, vsync = 0 in CTRL: cd0 = 2'b01 and cd1 = cd2 = 2'b00; during preamble, cd1 = 2'b01.
REQ-041 de low gap of 5 cycles between two active lines: timing_err = 1 and mode stays 3 through the gap region except 5 CTRL cycles; no PREAMBLE is emitted.
REQ-042 DVI_MODE = 1 with the REQ-039 stimulus: mode is only 0 or 3 and vde is high for exactly 4 cycles.
REQ-043 rst_pix asserted on the 3rd PREAMBLE cycle: the next cycle has mode = 0 and all outputs 0; the next de pulse yields a full 8 + 2 + N sequence.
REQ-044 640x480 frame timing, 2 frames: each line has exactly 8 PREAMBLE + 2 GUARD cycles before 640 VIDEO cycles, and timing_err stays 0.
